// File: rtl/snowbro2_vtimer_if.sv
// Video timing bundle between the Snow Bros 2 timing generator and its consumers.
// H_ADJ/V_ADJ exist only when SNOWBRO2_VTIMER_ADJ_EN is defined.
interface snowbro2_vtimer_if;
    logic       CEN675;
`ifdef SNOWBRO2_VTIMER_ADJ_EN
    logic [3:0] H_ADJ;
    logic [2:0] V_ADJ;
`endif
    logic [8:0] HCNT;
    logic [8:0] VCNT;
    logic       HBLANK;
    logic       VBLANK;
    logic       HSYNC;
    logic       VSYNC;
    logic       FRAME;
    logic       VINT;

    // Driver of the enable (and adjust values), consumer of the timing outputs.
    modport master (
        output CEN675,
`ifdef SNOWBRO2_VTIMER_ADJ_EN
        output H_ADJ,
        output V_ADJ,
`endif
        input  HCNT,
        input  VCNT,
        input  HBLANK,
        input  VBLANK,
        input  HSYNC,
        input  VSYNC,
        input  FRAME,
        input  VINT
    );

    // The timing generator itself.
    modport slave (
        input  CEN675,
`ifdef SNOWBRO2_VTIMER_ADJ_EN
        input  H_ADJ,
        input  V_ADJ,
`endif
        output HCNT,
        output VCNT,
        output HBLANK,
        output VBLANK,
        output HSYNC,
        output VSYNC,
        output FRAME,
        output VINT
    );
endinterface

// File: rtl/snowbro2_vtimer.sv
// Snow Bros 2 video timing generator: pixel/line counters, blanking, sync,
// frame toggle and one-cycle vblank interrupt, advanced by the 6.75 MHz enable.
// Optional macro SNOWBRO2_VTIMER_ADJ_EN adds signed sync shifts latched at frame wrap.
module snowbro2_vtimer #(
    parameter int unsigned H_TOTAL  = 432,
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned HS_START = 352,
    parameter int unsigned HS_END   = 384,
    parameter int unsigned V_TOTAL  = 262,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned VS_START = 244,
    parameter int unsigned VS_END   = 247
) (
    input  logic             CLK96,
    input  logic             RESETn,
    snowbro2_vtimer_if.slave vt
);
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [8:0] H_ACT  = 9'(H_ACTIVE);
    localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
    localparam logic signed [9:0] HS_LO = 10'(HS_START);
    localparam logic signed [9:0] HS_HI = 10'(HS_END);
    localparam logic signed [9:0] VS_LO = 10'(VS_START);
    localparam logic signed [9:0] VS_HI = 10'(VS_END);

    logic [8:0] hcnt_q, hcnt_d;
    logic [8:0] vcnt_q, vcnt_d;
    logic       hblank_q, hblank_d;
    logic       vblank_q, vblank_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       frame_q, frame_d;
    logic       vint_q, vint_d;
    logic       h_wrap, v_wrap;
    logic signed [9:0] h_adj_ext, v_adj_ext;
    logic signed [9:0] h_pos, v_pos;

`ifdef SNOWBRO2_VTIMER_ADJ_EN
    logic [3:0] h_adj_q, h_adj_d;
    logic [2:0] v_adj_q, v_adj_d;

    // Adjust values only change at the frame wrap so sync is never truncated.
    always_comb begin
        h_adj_d = h_adj_q;
        v_adj_d = v_adj_q;
        if (vt.CEN675 && h_wrap && v_wrap) begin
            h_adj_d = vt.H_ADJ;
            v_adj_d = vt.V_ADJ;
        end
        h_adj_ext = 10'(signed'(h_adj_d));
        v_adj_ext = 10'(signed'(v_adj_d));
    end

    // Adjust latches.
    always_ff @(posedge CLK96 or negedge RESETn) begin
        if (!RESETn) begin
            h_adj_q <= 4'd0;
            v_adj_q <= 3'd0;
        end else begin
            h_adj_q <= h_adj_d;
            v_adj_q <= v_adj_d;
        end
    end
`else
    // Fixed sync windows.
    always_comb begin
        h_adj_ext = 10'sd0;
        v_adj_ext = 10'sd0;
    end
`endif

    // Next counters and decodes; decodes use the next values so there is no skew.
    always_comb begin
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        hblank_d = hblank_q;
        vblank_d = vblank_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        frame_d  = frame_q;
        vint_d   = 1'b0;
        h_wrap   = (hcnt_q == H_LAST);
        v_wrap   = (vcnt_q == V_LAST);
        h_pos    = 10'(hcnt_q);
        v_pos    = 10'(vcnt_q);
        if (vt.CEN675) begin
            hcnt_d = h_wrap ? 9'd0 : hcnt_q + 9'd1;
            if (h_wrap) begin
                vcnt_d = v_wrap ? 9'd0 : vcnt_q + 9'd1;
                if (v_wrap) begin
                    frame_d = ~frame_q;
                end
            end
            h_pos    = 10'(hcnt_d);
            v_pos    = 10'(vcnt_d);
            hblank_d = (hcnt_d >= H_ACT);
            vblank_d = (vcnt_d >= V_ACT);
            hsync_d  = (h_pos >= HS_LO + h_adj_ext) && (h_pos < HS_HI + h_adj_ext);
            if (h_wrap) begin
                vsync_d = (v_pos >= VS_LO + v_adj_ext) && (v_pos < VS_HI + v_adj_ext);
                vint_d  = (vcnt_d == V_ACT);
            end
        end
    end

    // Timing state and registered outputs.
    always_ff @(posedge CLK96 or negedge RESETn) begin
        if (!RESETn) begin
            hcnt_q   <= 9'd0;
            vcnt_q   <= 9'd0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            frame_q  <= 1'b0;
            vint_q   <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            frame_q  <= frame_d;
            vint_q   <= vint_d;
        end
    end

    assign vt.HCNT   = hcnt_q;
    assign vt.VCNT   = vcnt_q;
    assign vt.HBLANK = hblank_q;
    assign vt.VBLANK = vblank_q;
    assign vt.HSYNC  = hsync_q;
    assign vt.VSYNC  = vsync_q;
    assign vt.FRAME  = frame_q;
    assign vt.VINT   = vint_q;
endmodule

// File: tb/tb_snowbro2_vtimer.sv
// Directed bench for snowbro2_vtimer. d_* is a default-parameter instance used for
// line-level checks; s_* shrinks the line to 40 pixels (default vertical timing)
// so whole frames fit in a short run.
module tb_snowbro2_vtimer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    snowbro2_vtimer_if d_if ();
    snowbro2_vtimer_if s_if ();

    snowbro2_vtimer dut_d (.CLK96(clk), .RESETn(rst_n), .vt(d_if));

    snowbro2_vtimer #(
        .H_TOTAL(40), .H_ACTIVE(24), .HS_START(28), .HS_END(32),
        .V_TOTAL(262), .V_ACTIVE(240), .VS_START(244), .VS_END(247)
    ) dut_s (.CLK96(clk), .RESETn(rst_n), .vt(s_if));

    // Observed events on the small instance.
    int vs_first, vs_last, vs_bad, vint_cnt, vb_rise_v, vb_rise_h, hs_first, hs_last, vmax;
    logic vs_prev, vb_prev;

    task automatic clear_stats();
        vs_first = -1; vs_last = -1; vs_bad = 0; vint_cnt = 0;
        vb_rise_v = -1; vb_rise_h = -1; hs_first = -1; hs_last = -1; vmax = 0;
        vs_prev = s_if.VSYNC; vb_prev = s_if.VBLANK;
    endtask

    task automatic observe();
        if (s_if.VSYNC && vs_first < 0) vs_first = int'(s_if.VCNT);
        if (s_if.VSYNC) vs_last = int'(s_if.VCNT);
        if (s_if.VSYNC != vs_prev && s_if.HCNT != 9'd0) vs_bad++;
        vs_prev = s_if.VSYNC;
        if (s_if.VBLANK && !vb_prev) begin
            vb_rise_v = int'(s_if.VCNT);
            vb_rise_h = int'(s_if.HCNT);
        end
        vb_prev = s_if.VBLANK;
        if (s_if.VINT) vint_cnt++;
        if (s_if.VCNT == 9'd5 && s_if.HSYNC) begin
            if (hs_first < 0) hs_first = int'(s_if.HCNT);
            hs_last = int'(s_if.HCNT);
        end
        if (int'(s_if.VCNT) > vmax) vmax = int'(s_if.VCNT);
    endtask

    // Back-to-back enables on the small instance, observing after each.
    task automatic run_s(input int n);
        for (int i = 0; i < n; i++) begin
            s_if.CEN675 = 1'b1;
            @(negedge clk);
            observe();
        end
        s_if.CEN675 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++; if (s_if.HCNT !== 9'd0) begin n_err++; $display("FAIL rst_hcnt: got %0d expected 0", s_if.HCNT); end
        n_vec++; if (s_if.VCNT !== 9'd0) begin n_err++; $display("FAIL rst_vcnt: got %0d expected 0", s_if.VCNT); end
        n_vec++; if ({s_if.HBLANK, s_if.VBLANK, s_if.HSYNC, s_if.VSYNC, s_if.FRAME, s_if.VINT} !== 6'b0) begin
            n_err++; $display("FAIL rst_flags: got %b expected 000000",
                {s_if.HBLANK, s_if.VBLANK, s_if.HSYNC, s_if.VSYNC, s_if.FRAME, s_if.VINT});
        end
        n_vec++; if ({d_if.HCNT, d_if.VCNT} !== 18'd0) begin n_err++; $display("FAIL rst_d_cnt: got %0d/%0d expected 0/0", d_if.HCNT, d_if.VCNT); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One line on the default instance with an enable every 16 cycles.
    task automatic test_line();
        int hb_first = -1, hsf = -1, hsl = -1, hmax = 0;
        for (int i = 0; i < 432; i++) begin
            d_if.CEN675 = 1'b1;
            @(negedge clk);
            d_if.CEN675 = 1'b0;
            if (d_if.HBLANK && hb_first < 0) hb_first = int'(d_if.HCNT);
            if (d_if.HSYNC && hsf < 0) hsf = int'(d_if.HCNT);
            if (d_if.HSYNC) hsl = int'(d_if.HCNT);
            if (int'(d_if.HCNT) > hmax) hmax = int'(d_if.HCNT);
            repeat (15) @(negedge clk);
        end
        n_vec++; if (hmax != 431) begin n_err++; $display("FAIL line_hmax: got %0d expected 431", hmax); end
        n_vec++; if (hb_first != 320) begin n_err++; $display("FAIL line_hblank_rise: got %0d expected 320", hb_first); end
        n_vec++; if (hsf != 352) begin n_err++; $display("FAIL line_hsync_first: got %0d expected 352", hsf); end
        n_vec++; if (hsl != 383) begin n_err++; $display("FAIL line_hsync_last: got %0d expected 383", hsl); end
        n_vec++; if (d_if.HCNT !== 9'd0 || d_if.VCNT !== 9'd1) begin
            n_err++; $display("FAIL line_wrap: got %0d/%0d expected 0/1", d_if.HCNT, d_if.VCNT);
        end
        n_vec++; if (d_if.HBLANK !== 1'b0 || d_if.HSYNC !== 1'b0) begin
            n_err++; $display("FAIL line_wrap_flags: got %b%b expected 00", d_if.HBLANK, d_if.HSYNC);
        end
    endtask

    // Idle enable holds every output; three consecutive enables advance three pixels.
    task automatic test_hold();
        logic [23:0] snap;
        int bad = 0;
        d_if.CEN675 = 1'b1;
        repeat (100) @(negedge clk);
        d_if.CEN675 = 1'b0;
        snap = {d_if.HCNT, d_if.VCNT, d_if.HBLANK, d_if.VBLANK, d_if.HSYNC, d_if.VSYNC, d_if.FRAME, d_if.VINT};
        n_vec++; if (d_if.HCNT !== 9'd100) begin n_err++; $display("FAIL hold_start: got %0d expected 100", d_if.HCNT); end
        repeat (1000) begin
            @(negedge clk);
            if ({d_if.HCNT, d_if.VCNT, d_if.HBLANK, d_if.VBLANK, d_if.HSYNC, d_if.VSYNC, d_if.FRAME, d_if.VINT} !== snap) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL hold_stable: got %0d changed cycles expected 0", bad); end
        d_if.CEN675 = 1'b1;
        repeat (3) @(negedge clk);
        d_if.CEN675 = 1'b0;
        @(negedge clk);
        n_vec++; if (d_if.HCNT !== 9'd103) begin n_err++; $display("FAIL burst3: got %0d expected 103", d_if.HCNT); end
    endtask

    // Full frame on the small instance, including the VINT pulse checks.
    task automatic test_frame_vint();
        clear_stats();
        run_s(240 * 40 - 1);
        n_vec++; if (s_if.VCNT !== 9'd239 || s_if.HCNT !== 9'd39) begin
            n_err++; $display("FAIL pre_vint_pos: got %0d/%0d expected 239/39", s_if.VCNT, s_if.HCNT);
        end
        n_vec++; if (vint_cnt != 0) begin n_err++; $display("FAIL vint_early: got %0d expected 0", vint_cnt); end
        run_s(1);
        n_vec++; if (s_if.VINT !== 1'b1 || s_if.VCNT !== 9'd240 || s_if.HCNT !== 9'd0) begin
            n_err++; $display("FAIL vint_pulse: got vint=%0d at %0d/%0d expected 1 at 240/0", s_if.VINT, s_if.VCNT, s_if.HCNT);
        end
        n_vec++; if (vb_rise_v != 240 || vb_rise_h != 0) begin
            n_err++; $display("FAIL vblank_rise: got %0d/%0d expected 240/0", vb_rise_v, vb_rise_h);
        end
        @(negedge clk);
        n_vec++; if (s_if.VINT !== 1'b0) begin n_err++; $display("FAIL vint_idle: got %0d expected 0", s_if.VINT); end
        run_s(3);
        n_vec++; if (vint_cnt != 1 || s_if.HCNT !== 9'd3) begin
            n_err++; $display("FAIL vint_cen_high: got count %0d hcnt %0d expected 1 and 3", vint_cnt, s_if.HCNT);
        end
        run_s(262 * 40 - 240 * 40 - 3);
        n_vec++; if (s_if.VCNT !== 9'd0 || s_if.HCNT !== 9'd0 || s_if.FRAME !== 1'b1) begin
            n_err++; $display("FAIL frame_wrap: got %0d/%0d frame %0d expected 0/0 frame 1", s_if.VCNT, s_if.HCNT, s_if.FRAME);
        end
        n_vec++; if (vmax != 261) begin n_err++; $display("FAIL vcnt_max: got %0d expected 261", vmax); end
        n_vec++; if (vs_first != 244 || vs_last != 246) begin
            n_err++; $display("FAIL vsync_window: got %0d..%0d expected 244..246", vs_first, vs_last);
        end
        n_vec++; if (vs_bad != 0) begin n_err++; $display("FAIL vsync_midline: got %0d expected 0", vs_bad); end
        n_vec++; if (vint_cnt != 1) begin n_err++; $display("FAIL vint_per_frame: got %0d expected 1", vint_cnt); end
        n_vec++; if (s_if.VBLANK !== 1'b0) begin n_err++; $display("FAIL vblank_fall: got %0d expected 0", s_if.VBLANK); end
    endtask

    // Asynchronous reset at VCNT=100, HCNT=30, away from any clock edge.
    task automatic test_reset_mid();
        run_s(100 * 40 + 30);
        n_vec++; if (s_if.VCNT !== 9'd100 || s_if.HCNT !== 9'd30 || s_if.HBLANK !== 1'b1 || s_if.HSYNC !== 1'b1 || s_if.FRAME !== 1'b1) begin
            n_err++; $display("FAIL pre_reset: got %0d/%0d hb%0d hs%0d fr%0d expected 100/30 hb1 hs1 fr1",
                s_if.VCNT, s_if.HCNT, s_if.HBLANK, s_if.HSYNC, s_if.FRAME);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({s_if.HCNT, s_if.VCNT, s_if.HBLANK, s_if.VBLANK, s_if.HSYNC, s_if.VSYNC, s_if.FRAME, s_if.VINT} !== 24'd0) begin
            n_err++; $display("FAIL async_reset: got %0d/%0d flags %b expected all 0", s_if.VCNT, s_if.HCNT,
                {s_if.HBLANK, s_if.VBLANK, s_if.HSYNC, s_if.VSYNC, s_if.FRAME, s_if.VINT});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_s(1);
        n_vec++; if (s_if.HCNT !== 9'd1 || s_if.VCNT !== 9'd0) begin
            n_err++; $display("FAIL post_reset: got %0d/%0d expected 1/0", s_if.HCNT, s_if.VCNT);
        end
    endtask

`ifdef SNOWBRO2_VTIMER_ADJ_EN
    // Sync shift takes effect only from the next frame.
    task automatic test_adj();
        s_if.H_ADJ = 4'b1100;
        s_if.V_ADJ = 3'b010;
        clear_stats();
        run_s(262 * 40 - 1);
        n_vec++; if (hs_first != 28 || hs_last != 31) begin
            n_err++; $display("FAIL adj_cur_hsync: got %0d..%0d expected 28..31", hs_first, hs_last);
        end
        n_vec++; if (vs_first != 244 || vs_last != 246) begin
            n_err++; $display("FAIL adj_cur_vsync: got %0d..%0d expected 244..246", vs_first, vs_last);
        end
        clear_stats();
        run_s(262 * 40);
        n_vec++; if (hs_first != 24 || hs_last != 27) begin
            n_err++; $display("FAIL adj_next_hsync: got %0d..%0d expected 24..27", hs_first, hs_last);
        end
        n_vec++; if (vs_first != 246 || vs_last != 248) begin
            n_err++; $display("FAIL adj_next_vsync: got %0d..%0d expected 246..248", vs_first, vs_last);
        end
        n_vec++; if (vb_rise_v != 240 || vint_cnt != 1) begin
            n_err++; $display("FAIL adj_blank_fixed: got vblank %0d vint %0d expected 240 and 1", vb_rise_v, vint_cnt);
        end
    endtask
`endif

    initial begin
        d_if.CEN675 = 1'b0;
        s_if.CEN675 = 1'b0;
`ifdef SNOWBRO2_VTIMER_ADJ_EN
        d_if.H_ADJ = 4'd0; d_if.V_ADJ = 3'd0;
        s_if.H_ADJ = 4'd0; s_if.V_ADJ = 3'd0;
`endif
        test_reset();
        test_line();
        test_hold();
        test_frame_vint();
        test_reset_mid();
`ifdef SNOWBRO2_VTIMER_ADJ_EN
        test_adj();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
